// File: rtl/dm_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dm_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    localparam int LOAD_W  = 3;
    localparam int STORE_W = 2;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_AUX = 1'b1;

endpackage

// File: rtl/dm_arbiter_if.sv
// Requester and memory-side bundle of the data-memory arbiter.
interface dm_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    import dm_arb_pkg::*;

    logic                m0_req;
    logic                m0_we;
    logic [AW-1:0]       m0_addr;
    logic [DW-1:0]       m0_wdata;
    logic [LOAD_W-1:0]   m0_load;
    logic [STORE_W-1:0]  m0_store;
    logic                m0_ack;
    logic [DW-1:0]       m0_rdata;
    logic                m0_stall;

    logic                m1_req;
    logic                m1_we;
    logic [AW-1:0]       m1_addr;
    logic [DW-1:0]       m1_wdata;
    logic [LOAD_W-1:0]   m1_load;
    logic [STORE_W-1:0]  m1_store;
    logic                m1_ack;
    logic [DW-1:0]       m1_rdata;

    logic                mem_we;
    logic [AW-1:0]       mem_addr;
    logic [DW-1:0]       mem_wdata;
    logic [LOAD_W-1:0]   mem_load;
    logic [STORE_W-1:0]  mem_store;
    logic [DW-1:0]       mem_rdata;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata, m0_load, m0_store,
        input  m1_req, m1_we, m1_addr, m1_wdata, m1_load, m1_store,
        input  mem_rdata,
        output m0_ack, m0_rdata, m0_stall,
        output m1_ack, m1_rdata,
        output mem_we, mem_addr, mem_wdata, mem_load, mem_store
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata, m0_load, m0_store,
        output m1_req, m1_we, m1_addr, m1_wdata, m1_load, m1_store,
        output mem_rdata,
        input  m0_ack, m0_rdata, m0_stall,
        input  m1_ack, m1_rdata,
        input  mem_we, mem_addr, mem_wdata, mem_load, mem_store
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: on a tie the requester not granted last wins.
module rr_arb2
    import dm_arb_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic grant_valid,
    output logic grant_idx
);

    always_comb begin
        grant_valid = req0 | req1;
        grant_idx   = REQ_CPU;
        unique case (1'b1)
            req0 & req1:  grant_idx = ~last_grant;
            req1 & ~req0: grant_idx = REQ_AUX;
            default:      grant_idx = REQ_CPU;
        endcase
    end

endmodule

// File: rtl/dm_arbiter.sv
// Shares the single-port data memory between the CPU port and an aux master.
module dm_arbiter
    import dm_arb_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
)(
    input logic         clk,
    input logic         rstn,
    dm_arbiter_if.slave bus
);

    state_t              state;
    logic                hold_idx;
    logic [AW-1:0]       hold_addr;
    logic [DW-1:0]       hold_wdata;
    logic [LOAD_W-1:0]   hold_load;
    logic [STORE_W-1:0]  hold_store;
    logic [DW-1:0]       rdata0;
    logic [DW-1:0]       rdata1;
    logic                last_grant;
    logic                ack0;
    logic                ack1;
    logic                mem_we_q;

    logic                req0;
    logic                req1;
    logic                gnt_valid;
    logic                gnt_idx;
    logic                win_we;
    logic [AW-1:0]       win_addr;
    logic [DW-1:0]       win_wdata;
    logic [LOAD_W-1:0]   win_load;
    logic [STORE_W-1:0]  win_store;

    // The requester being acked this cycle sits out the next arbitration.
    assign req0 = bus.m0_req & ~ack0;
    assign req1 = bus.m1_req & ~ack1;

    rr_arb2 u_arb (
        .req0        (req0),
        .req1        (req1),
        .last_grant  (last_grant),
        .grant_valid (gnt_valid),
        .grant_idx   (gnt_idx)
    );

    always_comb begin
        win_we    = bus.m0_we;
        win_addr  = bus.m0_addr;
        win_wdata = bus.m0_wdata;
        win_load  = bus.m0_load;
        win_store = bus.m0_store;
        if (gnt_idx == REQ_AUX) begin
            win_we    = bus.m1_we;
            win_addr  = bus.m1_addr;
            win_wdata = bus.m1_wdata;
            win_load  = bus.m1_load;
            win_store = bus.m1_store;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            hold_idx   <= REQ_CPU;
            hold_addr  <= '0;
            hold_wdata <= '0;
            hold_load  <= '0;
            hold_store <= '0;
            rdata0     <= '0;
            rdata1     <= '0;
            last_grant <= REQ_AUX;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            mem_we_q   <= 1'b0;
        end else begin
            ack0     <= 1'b0;
            ack1     <= 1'b0;
            mem_we_q <= 1'b0;
            unique case (state)
                IDLE, RESP: begin
                    if (gnt_valid) begin
                        hold_idx   <= gnt_idx;
                        hold_addr  <= win_addr;
                        hold_wdata <= win_wdata;
                        hold_load  <= win_load;
                        hold_store <= win_store;
                        last_grant <= gnt_idx;
                        mem_we_q   <= win_we;
                        state      <= BUSY;
                    end else begin
                        state <= IDLE;
                    end
                end
                BUSY: begin
                    if (hold_idx == REQ_CPU) begin
                        rdata0 <= bus.mem_rdata;
                        ack0   <= 1'b1;
                    end else begin
                        rdata1 <= bus.mem_rdata;
                        ack1   <= 1'b1;
                    end
                    state <= RESP;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.m0_ack    = ack0;
    assign bus.m1_ack    = ack1;
    assign bus.m0_rdata  = rdata0;
    assign bus.m1_rdata  = rdata1;
    assign bus.m0_stall  = bus.m0_req & ~ack0;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = hold_addr;
    assign bus.mem_wdata = hold_wdata;
    assign bus.mem_load  = hold_load;
    assign bus.mem_store = hold_store;

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed self-checking bench for dm_arbiter with a small word memory model.
module tb_dm_arbiter;
    import dm_arb_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    dm_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    dm_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    logic [DW-1:0] mem [64];
    assign bus.mem_rdata = mem[bus.mem_addr[7:2]];
    always @(posedge clk) if (bus.mem_we) mem[bus.mem_addr[7:2]] <= bus.mem_wdata;

    int n_chk    = 0;
    int n_pass   = 0;
    int we_cnt   = 0;
    int ack1_cnt = 0;
    int both_cnt = 0;

    always @(negedge clk) begin
        if (bus.mem_we) we_cnt++;
        if (bus.m1_ack) ack1_cnt++;
        if (bus.m0_ack && bus.m1_ack) both_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    int w0, a0, b0, t, last_t, ngr, cyc;
    logic [AW-1:0] h_addr [3];
    logic [DW-1:0] h_exp  [3];

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = '0;
        mem[4]  = 32'hDEADBEEF;
        mem[12] = 32'h11111111;
        {bus.m0_req, bus.m0_we, bus.m0_addr, bus.m0_wdata, bus.m0_load, bus.m0_store} = '0;
        {bus.m1_req, bus.m1_we, bus.m1_addr, bus.m1_wdata, bus.m1_load, bus.m1_store} = '0;

        // reset state
        bus.m0_req = 1'b1;
        #12;
        chk("rst_stall", bus.m0_stall, 1);
        chk("rst_ack0", bus.m0_ack, 0);
        chk("rst_ack1", bus.m1_ack, 0);
        chk("rst_mem_we", bus.mem_we, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_rdata0", bus.m0_rdata, 0);
        chk("rst_rdata1", bus.m1_rdata, 0);
        bus.m0_req = 1'b0;
        #1;
        chk("rst_stall_lo", bus.m0_stall, 0);
        @(negedge clk) rstn = 1'b1;
        tick();

        // m0 read of 0x10
        bus.m0_req  = 1'b1;
        bus.m0_addr = 32'h10;
        bus.m0_load = 3'b010;
        #1;
        chk("t1_stall_req", bus.m0_stall, 1);
        tick();
        chk("t1_busy_we", bus.mem_we, 0);
        chk("t1_busy_addr", bus.mem_addr, 32'h10);
        chk("t1_busy_load", bus.mem_load, 3'b010);
        chk("t1_busy_stall", bus.m0_stall, 1);
        chk("t1_busy_ack", bus.m0_ack, 0);
        tick();
        chk("t1_ack", bus.m0_ack, 1);
        chk("t1_rdata", bus.m0_rdata, 32'hDEADBEEF);
        chk("t1_stall_ack", bus.m0_stall, 0);
        bus.m0_req = 1'b0;
        tick();
        chk("t1_ack_pulse", bus.m0_ack, 0);

        // m1 word write to 0x20, then m0 reads it back
        w0 = we_cnt;
        bus.m1_req   = 1'b1;
        bus.m1_we    = 1'b1;
        bus.m1_addr  = 32'h20;
        bus.m1_wdata = 32'h12345678;
        bus.m1_store = 2'b10;
        tick();
        chk("t2_busy_we", bus.mem_we, 1);
        chk("t2_busy_store", bus.mem_store, 2'b10);
        chk("t2_busy_wdata", bus.mem_wdata, 32'h12345678);
        tick();
        chk("t2_ack1", bus.m1_ack, 1);
        chk("t2_mem", mem[8], 32'h12345678);
        bus.m1_req  = 1'b0;
        bus.m1_we   = 1'b0;
        bus.m0_req  = 1'b1;
        bus.m0_addr = 32'h20;
        tick();
        tick();
        chk("t2_ack0", bus.m0_ack, 1);
        chk("t2_rdata", bus.m0_rdata, 32'h12345678);
        bus.m0_req = 1'b0;
        chk("t2_we_pulses", we_cnt - w0, 1);
        tick();
        tick();

        // contention from reset
        rstn = 1'b0;
        #2;
        rstn = 1'b1;
        tick();
        b0 = both_cnt;
        bus.m0_addr = 32'h10;
        bus.m1_addr = 32'h20;
        bus.m0_req  = 1'b1;
        bus.m1_req  = 1'b1;
        t = 0; last_t = 0; ngr = 0;
        for (int c = 0; c < 40 && ngr < 8; c++) begin
            tick();
            t++;
            if (bus.m0_ack || bus.m1_ack) begin
                chk("t3_grant", bus.m1_ack, ngr % 2);
                if (bus.m1_ack) chk("t3_rdata1", bus.m1_rdata, 32'h12345678);
                else            chk("t3_rdata0", bus.m0_rdata, 32'hDEADBEEF);
                if (ngr > 0) chk("t3_gap", t - last_t, 2);
                last_t = t;
                ngr++;
            end
        end
        chk("t3_count", ngr, 8);
        bus.m0_req = 1'b0;
        bus.m1_req = 1'b0;
        tick();
        tick();
        tick();
        chk("t3_both_acks", both_cnt - b0, 0);

        // m1 drops req during BUSY
        w0 = we_cnt;
        a0 = ack1_cnt;
        bus.m1_req   = 1'b1;
        bus.m1_we    = 1'b1;
        bus.m1_addr  = 32'h40;
        bus.m1_wdata = 32'hCAFEF00D;
        bus.m1_store = 2'b10;
        tick();
        bus.m1_req   = 1'b0;
        bus.m1_addr  = 32'h3C;
        bus.m1_wdata = 32'h0;
        #1;
        chk("t4_addr_held", bus.mem_addr, 32'h40);
        tick();
        chk("t4_ack1", bus.m1_ack, 1);
        bus.m1_we = 1'b0;
        tick();
        tick();
        chk("t4_ack_once", ack1_cnt - a0, 1);
        chk("t4_we_once", we_cnt - w0, 1);
        chk("t4_mem", mem[16], 32'hCAFEF00D);

        // reset during a BUSY write to 0x30
        bus.m0_req   = 1'b1;
        bus.m0_we    = 1'b1;
        bus.m0_addr  = 32'h30;
        bus.m0_wdata = 32'hBADBAD00;
        bus.m0_store = 2'b10;
        tick();
        chk("t5_busy_we", bus.mem_we, 1);
        rstn       = 1'b0;
        bus.m0_req = 1'b0;
        bus.m0_we  = 1'b0;
        #1;
        chk("t5_rst_we", bus.mem_we, 0);
        chk("t5_rst_addr", bus.mem_addr, 0);
        chk("t5_rst_ack", bus.m0_ack, 0);
        tick();
        tick();
        chk("t5_no_ack", bus.m0_ack, 0);
        chk("t5_mem", mem[12], 32'h11111111);
        @(negedge clk) rstn = 1'b1;
        tick();

        // m0 holds req alone
        h_addr[0] = 32'h10; h_exp[0] = 32'hDEADBEEF;
        h_addr[1] = 32'h20; h_exp[1] = 32'h12345678;
        h_addr[2] = 32'h40; h_exp[2] = 32'hCAFEF00D;
        bus.m0_req  = 1'b1;
        bus.m0_addr = h_addr[0];
        for (int k = 0; k < 3; k++) begin
            cyc = 0;
            do begin
                tick();
                cyc++;
            end while (!bus.m0_ack && cyc < 10);
            chk("t6_gap", cyc, (k == 0) ? 2 : 3);
            chk("t6_rdata", bus.m0_rdata, h_exp[k]);
            if (k < 2) bus.m0_addr = h_addr[k + 1];
        end
        bus.m0_req = 1'b0;
        tick();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/dm_arbiter.md
# dm_arbiter

Two-requester arbiter that shares the single-port data memory between the CPU data port (requester 0) and a secondary master (requester 1), such as a program loader or DMA engine. It sits between the masters and `DM`. It captures one request at a time and drives the memory for exactly one cycle. It returns read data with a one-cycle acknowledge and alternates priority round-robin when both masters contend.

## Interface
Parameters:
- `AW`, default 32: address width.
- `DW`, default 32: data width.

Ports (clock and reset first):
- `clk`  in  1  single system clock; all state updates on the rising edge.
- `rstn`  in  1  reset, asynchronous, active-low.
- `m0_req`, `m1_req`  in  1  transaction request; held high until the matching ack.
- `m0_we`, `m1_we`  in  1  1 = write, 0 = read.
- `m0_addr`, `m1_addr`  in  AW  byte address.
- `m0_wdata`, `m1_wdata`  in  DW  write data.
- `m0_load`, `m1_load`  in  3  load width/sign code, passed to memory unchanged.
- `m0_store`, `m1_store`  in  2  store width code, passed to memory unchanged.
- `m0_ack`, `m1_ack`  out  1  one-cycle completion pulse.
- `m0_rdata`, `m1_rdata`  out  DW  read result, valid while the matching ack is high.
- `m0_stall`  out  1  `m0_req & ~m0_ack`; used to freeze the CPU PC and pipeline.
- `mem_we`  out  1  memory write enable.
- `mem_addr`  out  AW  memory address.
- `mem_wdata`  out  DW  memory write data.
- `mem_load`  out  3  memory load code.
- `mem_store`  out  2  memory store code.
- `mem_rdata`  in  DW  memory read data, combinational from `mem_addr`.

## Operation
- FSM states are IDLE, BUSY and RESP.
- IDLE:
  - If any request is high, run arbitration, capture the winner's we/addr/wdata/load/store and its index into holding registers, then go to BUSY.
  - Otherwise stay in IDLE.
- BUSY:
  - Drive the `mem_*` outputs from the holding registers.
  - On the closing edge, memory commits the write if `mem_we` is set.
  - On the same edge, `mem_rdata` is captured into the winner's rdata register. Capture happens for writes too; the value is a don't-care.
  - Go to RESP.
- RESP:
  - Assert the winner's ack.
  - Arbitrate again over the requests, excluding the requester whose ack is currently high.
  - If a request is pending, capture it and go to BUSY. Otherwise go to IDLE.
- Arbitration:
  - A single request wins outright.
  - If both requests are high, the requester not granted last wins.
  - The `last_grant` register updates on every capture.
- Outside BUSY, `mem_we` is 0. `mem_addr`, `mem_wdata`, `mem_load` and `mem_store` show the holding registers.
- Once a request is captured, the transaction always completes and acks, even if the request drops early.
- A requester that lowers req during BUSY still receives its ack.
- Requester inputs are sampled only at capture. Changes after capture are ignored.
- Starvation bound: with both masters requesting continuously, grants alternate 0,1,0,1…
- Reset values:
  - State is IDLE.
  - All holding registers and both rdata registers are 0.
  - `last_grant` is 1, so m0 wins the first tie.
  - Both acks are 0, `mem_we` is 0, and `m0_stall` equals `m0_req`.
- Asserting reset mid-transaction aborts it immediately: no ack is issued, and a write not yet edge-committed is lost.

## Timing
- Request sampled in IDLE at cycle N:
  - Cycle N+1 is BUSY, with memory driven.
  - Cycle N+2 is RESP, with ack high for exactly one cycle.
- Latency is 2 cycles from the capture edge to the ack cycle.
- Back-to-back throughput is one transaction per 2 cycles (BUSY, RESP, BUSY, …).
- A requester keeping req high through its own ack cycle is not re-served in that RESP. It is re-arbitrated at the next IDLE or RESP.
- `m0_stall` is combinational and falls in the ack cycle, so the CPU advances on that edge.
- The acks are never high simultaneously.

## Structure
- Package `dm_arb_pkg`:
  - state enum (IDLE, BUSY, RESP);
  - `LOAD_W = 3` and `STORE_W = 2`;
  - requester index constants `REQ_CPU = 0` and `REQ_AUX = 1`.
- Sub-module `rr_arb2`:
  - inputs: two requests and `last_grant`;
  - outputs: `grant_valid` and `grant_idx`;
  - purely combinational.
- The top level holds the FSM, holding registers, rdata registers and `last_grant`.

## Test plan
- Reset, then m0 reads 0x10, where memory holds 0xDEADBEEF.
  - `mem_we` = 0 in BUSY.
  - `m0_ack` is high in cycle 2 after the request.
  - `m0_rdata` = 0xDEADBEEF.
  - `m0_stall` is high for 2 cycles.
- m1 writes 0x12345678 to 0x20 with store = word, then m0 reads 0x20.
  - Single write pulse.
  - `m0_rdata` = 0x12345678.
- Both masters request from reset and hold req through 4 transactions each.
  - Grant order is 0,1,0,1,0,1,0,1.
  - No cycle has both acks high.
  - Throughput is 2 cycles per transaction.
- m1 raises req then drops it in the BUSY cycle.
  - `m1_ack` still pulses once.
  - The memory write still occurs.
- `rstn` is pulled low during a BUSY write to 0x30.
  - State is IDLE immediately, with no ack.
  - `mem_we` = 0 during reset.
  - Memory at 0x30 is unchanged.
- m0 holds req high with no m1 activity.
  - The same requester is served every 3 cycles (RESP → IDLE → BUSY).
  - Rdata tracks each new address.
